game_ctrl_param: RTL

Parametrised next-generation game controller for the side-scrolling "bird and tubes" game on the HDMI/LCD pipeline. It takes frame timing (vs_in) and UART key bytes. It produces the game state, the bird Y position, N_TUBE tube positions and gap heights as packed buses, and a score. It sits between the UART receiver and the sprite renderer, and adds several things the fixed 5-tube controller lacks: LFSR gap heights, collision against every on-screen tube, scoring, and restart without reset.

---
 rtl/game_ctrl_param.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/game_ctrl_param.sv
// Parametrised bird-and-tubes game controller: frame/key edge detect, LFSR gaps, scroll, collision, score.
// Optional high-score register enabled by defining GAME_HISCORE_EN.

module game_ctrl_param_slot #(
  parameter int TUBE_W = 32,
  parameter int GAP_H  = 64,
  parameter int BIRD_X = 184,
  parameter int BIRD_W = 32
) (
  input  logic [11:0] x_i,
  input  logic [11:0] h_i,
  input  logic [11:0] bird_y_i,
  output logic        hit_o,
  output logic        pass_o
);
  localparam logic [12:0] TW = 13'(TUBE_W);
  localparam logic [12:0] GH = 13'(GAP_H);
  localparam logic [12:0] BX = 13'(BIRD_X);
  localparam logic [12:0] BW = 13'(BIRD_W);

  logic [12:0] x, h, by;
  logic        busy, hovl, vhit;

  // 13-bit widening keeps x+TUBE_W and h+GAP_H from wrapping.
  assign x    = {1'b0, x_i};
  assign h    = {1'b0, h_i};
  assign by   = {1'b0, bird_y_i};
  assign busy = |h_i;
  assign hovl = ((x + TW) > BX) && (x < (BX + BW));
  assign vhit = (by < h) || (by > (h + GH));

  assign hit_o  = busy & hovl & vhit;
  assign pass_o = busy & (x == (BX - TW));
endmodule

module game_ctrl_param #(
  parameter int          N_TUBE     = 5,
  parameter int          SCR_W      = 640,
  parameter int          SCR_H      = 480,
  parameter int          TUBE_W     = 32,
  parameter int          TUBE_PITCH = 128,
  parameter int          GAP_H      = 64,
  parameter int          BIRD_X     = 184,
  parameter int          BIRD_W     = 32,
  parameter int          BIRD_Y0    = 240,
  parameter int          JUMP       = 20,
  parameter int          FALL_DIV   = 2,
  parameter int          H_MIN      = 100,
  parameter logic [7:0]  JUMP_KEY   = 8'h30
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    vs_in,
  input  logic [7:0]              rx_data,
  input  logic                    rx_data_valid,
  output logic [1:0]              state,
  output logic [11:0]             bird_y,
  output logic [12*N_TUBE-1:0]    tube_x,
  output logic [12*N_TUBE-1:0]    tube_h,
  output logic [15:0]             score,
  output logic [15:0]             hiscore
);
  if ((H_MIN + 240 + GAP_H > SCR_H) || (N_TUBE < 2) || (N_TUBE > 8) ||
      (FALL_DIV < 1) || (FALL_DIV > 15)) begin : g_param_err
    $error("game_ctrl_param: illegal parameter set");
  end

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_OVER = 2'd1, S_PLAY = 2'd2} state_e;
  typedef logic [N_TUBE-1:0][11:0] slots_t;

  function automatic slots_t init_x();
    slots_t v;
    for (int i = 0; i < N_TUBE; i++) v[i] = (i == N_TUBE-1) ? 12'(SCR_W + 60) : 12'd1600;
    return v;
  endfunction

  function automatic slots_t init_h();
    slots_t v;
    for (int i = 0; i < N_TUBE; i++) v[i] = (i == N_TUBE-1) ? 12'(H_MIN) : 12'd0;
    return v;
  endfunction

  localparam slots_t      TX_RST     = init_x();
  localparam slots_t      TH_RST     = init_h();
  localparam logic [11:0] BIRD_RST   = 12'(BIRD_Y0);
  localparam logic [11:0] JUMP12     = 12'(JUMP);
  localparam logic [11:0] SCROLL_MIN = 12'(SCR_W - TUBE_PITCH);
  localparam logic [11:0] NEW_X      = 12'(SCR_W);
  localparam logic [11:0] H12        = 12'(H_MIN);
  localparam logic [3:0]  FALL_TOP   = 4'(FALL_DIV - 1);
  localparam logic [12:0] Y_LO       = 13'd5;
  localparam logic [12:0] Y_HI       = 13'(SCR_H - 5);

  state_e      state_q, state_d;
  logic [11:0] bird_q, bird_d;
  logic [3:0]  fall_q, fall_d;
  slots_t      tx_q, tx_d, th_q, th_d;
  logic [15:0] score_q, score_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic        vs_q, rxv_q;

  logic              tick, key, jump, oob;
  logic [N_TUBE-1:0] hit, pass;

  assign tick = vs_q & ~vs_in;
  assign key  = rx_data_valid & ~rxv_q;
  assign jump = key && (rx_data == JUMP_KEY);
  assign oob  = ({1'b0, bird_q} < Y_LO) || ({1'b0, bird_q} > Y_HI);

  // Fibonacci taps 16,14,13,11 in right-shift form.
  assign lfsr_d = tick ? {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]} : lfsr_q;

  for (genvar i = 0; i < N_TUBE; i++) begin : g_slot
    game_ctrl_param_slot #(
      .TUBE_W (TUBE_W),
      .GAP_H  (GAP_H),
      .BIRD_X (BIRD_X),
      .BIRD_W (BIRD_W)
    ) u_slot (
      .x_i      (tx_q[i]),
      .h_i      (th_q[i]),
      .bird_y_i (bird_q),
      .hit_o    (hit[i]),
      .pass_o   (pass[i])
    );
  end

  always_comb begin
    state_d = state_q;
    bird_d  = bird_q;
    fall_d  = fall_q;
    tx_d    = tx_q;
    th_d    = th_q;
    score_d = score_q;
    unique case (state_q)
      S_IDLE: begin
        bird_d = BIRD_RST;
        fall_d = '0;
        tx_d   = TX_RST;
        th_d   = TH_RST;
        if (key) begin
          state_d = S_PLAY;
          score_d = '0;
        end
      end
      S_PLAY: begin
        // A jump swallows the gravity step of a coincident tick.
        if (jump) begin
          bird_d = (bird_q < JUMP12) ? 12'd0 : bird_q - JUMP12;
        end else if (tick) begin
          if (fall_q == FALL_TOP) begin
            fall_d = '0;
            bird_d = bird_q + 12'd1;
          end else begin
            fall_d = fall_q + 4'd1;
          end
        end
        if (tick) begin
          if (tx_q[N_TUBE-1] >= SCROLL_MIN) begin
            for (int i = 0; i < N_TUBE; i++) tx_d[i] = tx_q[i] - 12'd1;
          end else begin
            for (int i = 0; i < N_TUBE-1; i++) begin
              tx_d[i] = tx_q[i+1];
              th_d[i] = th_q[i+1];
            end
            tx_d[N_TUBE-1] = NEW_X;
            th_d[N_TUBE-1] = H12 + {4'd0, lfsr_q[3:0], 4'd0};
          end
          if ((|pass) && (score_q != 16'hFFFF)) score_d = score_q + 16'd1;
        end
        if ((|hit) || oob) state_d = S_OVER;
      end
      S_OVER: begin
        if (jump) begin
          state_d = S_IDLE;
          bird_d  = BIRD_RST;
          fall_d  = '0;
          tx_d    = TX_RST;
          th_d    = TH_RST;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      bird_q  <= BIRD_RST;
      fall_q  <= '0;
      tx_q    <= TX_RST;
      th_q    <= TH_RST;
      score_q <= '0;
      lfsr_q  <= 16'hACE1;
      vs_q    <= 1'b0;
      rxv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bird_q  <= bird_d;
      fall_q  <= fall_d;
      tx_q    <= tx_d;
      th_q    <= th_d;
      score_q <= score_d;
      lfsr_q  <= lfsr_d;
      vs_q    <= vs_in;
      rxv_q   <= rx_data_valid;
    end
  end

`ifdef GAME_HISCORE_EN
  logic [15:0] hi_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
    end else if ((state_q == S_PLAY) && (state_d == S_OVER) && (score_q > hi_q)) begin
      hi_q <= score_q;
    end
  end

  assign hiscore = hi_q;
`else
  assign hiscore = 16'd0;
`endif

  assign state  = state_q;
  assign bird_y = bird_q;
  assign tube_x = tx_q;
  assign tube_h = th_q;
  assign score  = score_q;
endmodule
